id_ex_reg: RTL and testbench

ID/EX pipeline register of the 5-stage RISC-V core. It sits directly downstream of the register file and latches the decoded instruction and the rs1/rs2 operands it produces. It contains load-use hazard detection, which inserts one bubble and raises a stall for the PC and IF/ID registers. It also handles branch/jump flush and counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_reg_pkg.sv | 35 +++
 rtl/id_ex_reg_if.sv | 47 ++++
 rtl/id_ex_reg_hazard_detect.sv | 24 ++
 rtl/id_ex_reg.sv | 113 +++++++++++
 tb/tb_id_ex_reg.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX stage: control-word bit positions,
// ALU operation encodings and the bubble (NOP) control word.
package id_ex_reg_pkg;

    // Bit positions inside the 8-bit control word {RegWrite .. Jump, 1'b0}.
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_JUMP     = 1;

    // All-zero control has no architectural side effect downstream.
    localparam logic [7:0] CTRL_NOP = 8'h00;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_SLL    = 4'h2,
        ALU_SLT    = 4'h3,
        ALU_SLTU   = 4'h4,
        ALU_XOR    = 4'h5,
        ALU_SRL    = 4'h6,
        ALU_SRA    = 4'h7,
        ALU_OR     = 4'h8,
        ALU_AND    = 4'h9,
        ALU_PASS_B = 4'hA
    } alu_op_e;

    function automatic logic is_load(input logic [7:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Bundle between the decode stage and the ID/EX register: decoded ID fields
// and redirect in, stall request and latched EX fields out.
interface id_ex_reg_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [4:0]       id_rs1Addr;
    logic [4:0]       id_rs2Addr;
    logic             id_useRs1;
    logic             id_useRs2;
    logic [4:0]       id_rdAddr;
    logic [XLEN-1:0]  id_rs1Data;
    logic [XLEN-1:0]  id_rs2Data;
    logic [XLEN-1:0]  id_imm;
    logic [7:0]       id_ctrl;
    logic [3:0]       id_aluOp;
    logic             flush;

    logic             stall;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1Data;
    logic [XLEN-1:0]  ex_rs2Data;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_rs1Addr;
    logic [4:0]       ex_rs2Addr;
    logic [4:0]       ex_rdAddr;
    logic [7:0]       ex_ctrl;
    logic [3:0]       ex_aluOp;
    logic [CNT_W-1:0] bubbleCount;

    modport master (
        output id_valid, id_pc, id_rs1Addr, id_rs2Addr, id_useRs1, id_useRs2,
               id_rdAddr, id_rs1Data, id_rs2Data, id_imm, id_ctrl, id_aluOp, flush,
        input  stall, ex_valid, ex_pc, ex_rs1Data, ex_rs2Data, ex_imm,
               ex_rs1Addr, ex_rs2Addr, ex_rdAddr, ex_ctrl, ex_aluOp, bubbleCount
    );

    modport slave (
        input  id_valid, id_pc, id_rs1Addr, id_rs2Addr, id_useRs1, id_useRs2,
               id_rdAddr, id_rs1Data, id_rs2Data, id_imm, id_ctrl, id_aluOp, flush,
        output stall, ex_valid, ex_pc, ex_rs1Data, ex_rs2Data, ex_imm,
               ex_rs1Addr, ex_rs2Addr, ex_rdAddr, ex_ctrl, ex_aluOp, bubbleCount
    );
endinterface

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use detector: EX holds a load whose non-x0 destination is a source
// that the ID instruction actually reads. Purely combinational.
module id_ex_reg_hazard_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       id_valid_i,
    input  logic       id_use_rs1_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] id_rs2_addr_i,
    output logic       hazard_o
);
    logic ex_is_load;
    logic rs1_dep;
    logic rs2_dep;

    assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != 5'd0);
    assign rs1_dep    = id_use_rs1_i & (ex_rd_addr_i == id_rs1_addr_i);
    assign rs2_dep    = id_use_rs2_i & (ex_rd_addr_i == id_rs2_addr_i);

    // Both sources hitting the same load still yields a single hazard.
    assign hazard_o   = ex_is_load & id_valid_i & (rs1_dep | rs2_dep);
endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, redirect flush
// and a saturating count of inserted load-use bubbles.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    id_ex_reg_if.slave  bus
);
    logic             ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
    logic [XLEN-1:0]  ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0]  ex_rs2_data_q, ex_rs2_data_d;
    logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
    logic [4:0]       ex_rs1_addr_q, ex_rs1_addr_d;
    logic [4:0]       ex_rs2_addr_q, ex_rs2_addr_d;
    logic [4:0]       ex_rd_addr_q, ex_rd_addr_d;
    logic [7:0]       ex_ctrl_q, ex_ctrl_d;
    logic [3:0]       ex_alu_op_q, ex_alu_op_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             hazard;

    id_ex_reg_hazard_detect u_hazard (
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (is_load(ex_ctrl_q)),
        .ex_rd_addr_i  (ex_rd_addr_q),
        .id_valid_i    (bus.id_valid),
        .id_use_rs1_i  (bus.id_useRs1),
        .id_rs1_addr_i (bus.id_rs1Addr),
        .id_use_rs2_i  (bus.id_useRs2),
        .id_rs2_addr_i (bus.id_rs2Addr),
        .hazard_o      (hazard)
    );

    // A redirect kills the ID instruction, so it must not also hold the front end.
    assign bus.stall = hazard & ~bus.flush;

    always_comb begin
        ex_valid_d    = 1'b0;
        ex_pc_d       = '0;
        ex_rs1_data_d = '0;
        ex_rs2_data_d = '0;
        ex_imm_d      = '0;
        ex_rs1_addr_d = '0;
        ex_rs2_addr_d = '0;
        ex_rd_addr_d  = '0;
        ex_ctrl_d     = CTRL_NOP;
        ex_alu_op_d   = ALU_ADD;
        bubble_cnt_d  = bubble_cnt_q;

        if (bus.flush) begin
            // bubble, count untouched
        end else if (hazard) begin
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_d    = bus.id_valid;
            ex_pc_d       = bus.id_pc;
            ex_rs1_data_d = bus.id_rs1Data;
            ex_rs2_data_d = bus.id_rs2Data;
            ex_imm_d      = bus.id_imm;
            ex_rs1_addr_d = bus.id_rs1Addr;
            ex_rs2_addr_d = bus.id_rs2Addr;
            ex_rd_addr_d  = bus.id_rdAddr;
            ex_ctrl_d     = bus.id_valid ? bus.id_ctrl : CTRL_NOP;
            ex_alu_op_d   = bus.id_aluOp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_addr_q <= '0;
            ex_rs2_addr_q <= '0;
            ex_rd_addr_q  <= '0;
            ex_ctrl_q     <= CTRL_NOP;
            ex_alu_op_q   <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_addr_q <= ex_rs1_addr_d;
            ex_rs2_addr_q <= ex_rs2_addr_d;
            ex_rd_addr_q  <= ex_rd_addr_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_alu_op_q   <= ex_alu_op_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_rs1Data  = ex_rs1_data_q;
    assign bus.ex_rs2Data  = ex_rs2_data_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rs1Addr  = ex_rs1_addr_q;
    assign bus.ex_rs2Addr  = ex_rs2_addr_q;
    assign bus.ex_rdAddr   = ex_rd_addr_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.ex_aluOp    = ex_alu_op_q;
    assign bus.bubbleCount = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed vector table, randomized run against a
// behavioural model of the EX stage, and counter saturation on a 4-bit build.
module tb_id_ex_reg;
    import id_ex_reg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    always #5 clk = ~clk;

    id_ex_reg_if #(.XLEN(32), .CNT_W(32)) bus ();
    id_ex_reg_if #(.XLEN(32), .CNT_W(4))  bus4 ();

    id_ex_reg #(.XLEN(32), .CNT_W(32)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    id_ex_reg #(.XLEN(32), .CNT_W(4))  dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic [3:0]  alu;
    } ex_t;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1a;
        logic        use1;
        logic [4:0]  rs2a;
        logic        use2;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic        exp_stall;
        logic        exp_latch;   // 1: EX takes the ID fields, 0: EX becomes all-zero
        logic [31:0] exp_cnt;
    } vec_t;

    localparam logic [31:0] T_RS1D = 32'h0000_0011;
    localparam logic [31:0] T_RS2D = 32'h0000_0022;
    localparam logic [31:0] T_IMM  = 32'hFFFF_FFF0;
    localparam logic [3:0]  T_ALU  = 4'h2;
    localparam logic [7:0]  LW     = 8'hD8;
    localparam logic [7:0]  ADD    = 8'h80;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic ex_t dut_ex();
        ex_t e;
        e = '{valid: bus.ex_valid, pc: bus.ex_pc, rs1d: bus.ex_rs1Data, rs2d: bus.ex_rs2Data,
              imm: bus.ex_imm, rs1a: bus.ex_rs1Addr, rs2a: bus.ex_rs2Addr, rd: bus.ex_rdAddr,
              ctrl: bus.ex_ctrl, alu: bus.ex_aluOp};
        return e;
    endfunction

    // EX holds a real load to a non-zero register, and ID genuinely reads it.
    function automatic logic load_use(input ex_t e, input logic v, input logic [4:0] a1,
                                      input logic u1, input logic [4:0] a2, input logic u2);
        logic reads_it;
        reads_it = (u1 && a1 == e.rd) || (u2 && a2 == e.rd);
        return e.valid && e.ctrl[CTRL_MEMREAD] && (e.rd != 5'd0) && v && reads_it;
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic v, input logic [31:0] pc,
                                input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                                input logic u2, input logic [4:0] rd, input logic [7:0] ctrl,
                                input logic es, input logic el, input logic [31:0] ec);
        vec_t t;
        t = '{rst: r, flush: f, valid: v, pc: pc, rs1a: a1, use1: u1, rs2a: a2, use2: u2,
              rd: rd, ctrl: ctrl, exp_stall: es, exp_latch: el, exp_cnt: ec};
        return t;
    endfunction

    task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] pc,
                         input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [7:0] ctrl, input logic [3:0] alu);
        rst = r; bus.flush = f; bus.id_valid = v; bus.id_pc = pc;
        bus.id_rs1Addr = a1; bus.id_useRs1 = u1; bus.id_rs2Addr = a2; bus.id_useRs2 = u2;
        bus.id_rdAddr = rd; bus.id_rs1Data = d1; bus.id_rs2Data = d2; bus.id_imm = imm;
        bus.id_ctrl = ctrl; bus.id_aluOp = alu;
    endtask

    task automatic drive4(input logic r, input logic [4:0] a1, input logic u1,
                          input logic [4:0] rd, input logic [7:0] ctrl);
        rst4 = r; bus4.flush = 1'b0; bus4.id_valid = 1'b1; bus4.id_pc = 32'h400;
        bus4.id_rs1Addr = a1; bus4.id_useRs1 = u1; bus4.id_rs2Addr = 5'd0; bus4.id_useRs2 = 1'b0;
        bus4.id_rdAddr = rd; bus4.id_rs1Data = '0; bus4.id_rs2Data = '0; bus4.id_imm = '0;
        bus4.id_ctrl = ctrl; bus4.id_aluOp = 4'h0;
    endtask

    vec_t tbl [$];

    initial begin
        ex_t   exp_e;
        ex_t   m;
        logic [31:0] mcnt;
        logic  r, f, v, u1, u2;
        logic [4:0] a1, a2, rd;
        logic [31:0] pc, d1, d2, imm;
        logic [7:0] ctrl;
        logic [3:0] alu;
        logic  exp_s;

        drive4(1'b1, 5'd0, 1'b0, 5'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9,
              $urandom, $urandom, $urandom, 8'hC0, 4'h3);

        // rst, flush, valid, pc, rs1, use1, rs2, use2, rd, ctrl | stall, latch, count
        tbl.push_back(mk(1,0,1,32'h200, 5,1, 5,1,  5, LW,  0,0,0));
        tbl.push_back(mk(1,0,1,32'h204, 1,1, 2,1,  3, ADD, 0,0,0));
        tbl.push_back(mk(0,0,1,32'h100, 1,1, 2,1,  3, ADD, 0,1,0)); // plain latch
        tbl.push_back(mk(0,0,1,32'h104, 2,1, 0,0,  5, LW,  0,1,0)); // lw x5
        tbl.push_back(mk(0,0,1,32'h108, 5,1, 7,1,  6, ADD, 1,0,1)); // add x6,x5,x7 -> bubble
        tbl.push_back(mk(0,0,1,32'h108, 5,1, 7,1,  6, ADD, 0,1,1)); // add proceeds
        tbl.push_back(mk(0,0,1,32'h10C, 1,1, 0,0,  0, LW,  0,1,1)); // lw x0
        tbl.push_back(mk(0,0,1,32'h110, 0,1, 0,0,  9, ADD, 0,1,1)); // reads x0
        tbl.push_back(mk(0,0,1,32'h114, 1,1, 0,0,  5, LW,  0,1,1)); // lw x5
        tbl.push_back(mk(0,0,1,32'h118, 3,1, 5,0, 10, ADD, 0,1,1)); // rs2=x5 unused
        tbl.push_back(mk(0,0,1,32'h11C, 1,1, 0,0,  5, LW,  0,1,1)); // lw x5
        tbl.push_back(mk(0,1,1,32'h120, 5,1, 5,1, 11, ADD, 0,0,1)); // flush beats hazard
        tbl.push_back(mk(0,0,1,32'h124, 1,1, 0,0,  5, LW,  0,1,1)); // lw x5
        tbl.push_back(mk(0,0,1,32'h128, 5,1, 5,1, 12, ADD, 1,0,2)); // rs1==rs2==rd: one bubble
        tbl.push_back(mk(0,0,0,32'h12C, 1,1, 0,0,  7, ADD, 0,1,2)); // invalid ID
        tbl.push_back(mk(0,0,1,32'h130, 1,1, 0,0,  5, LW,  0,1,2)); // lw x5
        tbl.push_back(mk(0,0,0,32'h134, 5,1, 5,1,  8, ADD, 0,1,2)); // dependent but invalid
        tbl.push_back(mk(0,0,1,32'h138, 1,1, 0,0,  5, LW,  0,1,2)); // lw x5
        tbl.push_back(mk(1,0,1,32'h13C, 5,1, 0,0,  6, ADD, 1,0,0)); // reset mid-stall
        tbl.push_back(mk(0,0,1,32'h13C, 5,1, 0,0,  6, ADD, 0,1,0));
        tbl.push_back(mk(0,1,1,32'h140, 1,1, 2,1,  3, ADD, 0,0,0)); // plain flush
        tbl.push_back(mk(0,0,1,32'h144, 1,1, 0,0,  5, LW,  0,1,0)); // lw x5
        tbl.push_back(mk(0,0,1,32'h148, 1,1, 5,1, 13, ADD, 1,0,1)); // rs2-only dependency

        @(posedge clk);
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].flush, tbl[i].valid, tbl[i].pc, tbl[i].rs1a, tbl[i].use1,
                  tbl[i].rs2a, tbl[i].use2, tbl[i].rd, T_RS1D, T_RS2D, T_IMM, tbl[i].ctrl, T_ALU);
            #1;
            chk($sformatf("vec%0d stall", i), 256'(bus.stall), 256'(tbl[i].exp_stall));
            @(posedge clk);
            #1;
            exp_e = '0;
            if (tbl[i].exp_latch) begin
                exp_e = '{valid: tbl[i].valid, pc: tbl[i].pc, rs1d: T_RS1D, rs2d: T_RS2D,
                          imm: T_IMM, rs1a: tbl[i].rs1a, rs2a: tbl[i].rs2a, rd: tbl[i].rd,
                          ctrl: tbl[i].valid ? tbl[i].ctrl : 8'h00, alu: T_ALU};
            end
            chk($sformatf("vec%0d ex", i), 256'(dut_ex()), 256'(exp_e));
            chk($sformatf("vec%0d bubbleCount", i), 256'(bus.bubbleCount), 256'(tbl[i].exp_cnt));
        end

        // Randomized run against the model; start from a known reset state.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0, '0, '0);
        @(posedge clk);
        m = '0;
        mcnt = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            r    = ($urandom_range(0, 59) == 0);
            f    = ($urandom_range(0, 7) == 0);
            v    = ($urandom_range(0, 7) != 0);
            pc   = $urandom;
            a1   = 5'($urandom_range(0, 3));
            a2   = 5'($urandom_range(0, 3));
            u1   = 1'($urandom_range(0, 1));
            u2   = 1'($urandom_range(0, 1));
            rd   = 5'($urandom_range(0, 3));
            d1   = $urandom;
            d2   = $urandom;
            imm  = $urandom;
            ctrl = 8'($urandom) & 8'hBE;
            if ($urandom_range(0, 1) == 1) ctrl[CTRL_MEMREAD] = 1'b1;
            alu  = 4'($urandom_range(0, 10));
            drive(r, f, v, pc, a1, u1, a2, u2, rd, d1, d2, imm, ctrl, alu);
            exp_s = load_use(m, v, a1, u1, a2, u2) && !f;
            #1;
            chk($sformatf("rnd%0d stall", i), 256'(bus.stall), 256'(exp_s));
            @(posedge clk);
            if (r) begin
                m = '0;
                mcnt = '0;
            end else if (f) begin
                m = '0;
            end else if (load_use(m, v, a1, u1, a2, u2)) begin
                m = '0;
                if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
            end else begin
                m = '{valid: v, pc: pc, rs1d: d1, rs2d: d2, imm: imm, rs1a: a1, rs2a: a2,
                      rd: rd, ctrl: v ? ctrl : 8'h00, alu: alu};
            end
            #1;
            chk($sformatf("rnd%0d ex", i), 256'(dut_ex()), 256'(m));
            chk($sformatf("rnd%0d bubbleCount", i), 256'(bus.bubbleCount), 256'(mcnt));
        end

        // Saturation on the 4-bit counter: 17 load-use events must stop at 15.
        @(negedge clk);
        drive4(1'b0, 5'd1, 1'b1, 5'd5, LW);
        @(posedge clk);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            drive4(1'b0, 5'd5, 1'b1, 5'd6, ADD);
            #1;
            if (k == 1 || k == 17)
                chk($sformatf("sat%0d stall", k), 256'(bus4.stall), 256'(1'b1));
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d bubbleCount", k), 256'(bus4.bubbleCount),
                256'((k > 15) ? 15 : k));
            @(negedge clk);
            drive4(1'b0, 5'd1, 1'b1, 5'd5, LW);
            @(posedge clk);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
